// File: rtl/ad9833_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// ad9833_sweep_ctrl
// Frequency-sweep sequencer for the ad9833if SPI block. Latches a
// start/stop/step tuning-word triple and a dwell time, then issues one
// three-word transfer (control, FREQ0 LSB, FREQ0 MSB) per sweep point using
// the go / good_to_reset_go / send_complete handshake. Supports single-shot
// or continuous sweeps and an abort that only takes effect at safe points.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_start               start a sweep (sampled only when idle)
//   i_abort               request stop at the next safe point
//   i_continuous          repeat the sweep until aborted (latched on start)
//   i_mode                waveform select (sine/triangle/square-div2/square)
//   i_f_start/stop/step   28-bit tuning words for the sweep
//   i_dwell               cycles to hold each point after its transfer
//   i_good_to_reset_go    ad9833if accepted the request
//   i_send_complete       ad9833if finished the three-word transfer
//   o_go                  transfer request
//   o_control/o_adreg0/1  words presented to ad9833if
//   o_cur_ftw             tuning word programmed or in flight
//   o_busy                high whenever not idle
//   o_done                one-cycle pulse at sweep end (normal or abort)
// ---------------------------------------------------------------------------
module ad9833_sweep_ctrl #(
    parameter int unsigned DWELL_W   = 32,
    parameter logic [15:0] CTRL_BASE = 16'h2000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_continuous,
    input  logic [1:0]         i_mode,
    input  logic [27:0]        i_f_start,
    input  logic [27:0]        i_f_stop,
    input  logic [27:0]        i_f_step,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_good_to_reset_go,
    input  logic               i_send_complete,
    output logic               o_go,
    output logic [15:0]        o_control,
    output logic [15:0]        o_adreg0,
    output logic [15:0]        o_adreg1,
    output logic [27:0]        o_cur_ftw,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned FTW_W     = 28;
    localparam int unsigned HALF_W    = 14;
    localparam logic [1:0]  FREQ0_TAG = 2'b01;
    localparam logic [15:0] ADREG_RST = 16'h4000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_SEND_WAIT,
        S_DWELL,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state;
    logic [FTW_W-1:0]   f_start;
    logic [FTW_W-1:0]   f_stop;
    logic [FTW_W-1:0]   f_step;
    logic [DWELL_W-1:0] dwell_lat;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [1:0]         mode_lat;
    logic               cont_lat;
    logic               dir_up;
    logic               abort_lat;

    logic [FTW_W:0]     up_sum;
    logic [FTW_W:0]     dn_diff;
    logic [FTW_W-1:0]   next_ftw;
    logic               at_end;
    logic               abort_now;

    // Waveform select bits OR-ed into the control word.
    function automatic logic [15:0] mode_bits(input logic [1:0] m);
        logic [15:0] b;
        case (m)
            2'd0:    b = 16'h0000;
            2'd1:    b = 16'h0002;
            2'd2:    b = 16'h0020;
            default: b = 16'h0028;
        endcase
        return b;
    endfunction

    // Next sweep point; the extra MSB catches 28-bit wrap in either direction,
    // and any overshoot of the stop word clamps onto it.
    always_comb begin
        up_sum    = {1'b0, o_cur_ftw} + {1'b0, f_step};
        dn_diff   = {1'b0, o_cur_ftw} - {1'b0, f_step};
        next_ftw  = f_stop;
        if (dir_up) begin
            if (!up_sum[FTW_W] && (up_sum[FTW_W-1:0] < f_stop))
                next_ftw = up_sum[FTW_W-1:0];
        end else begin
            if (!dn_diff[FTW_W] && (dn_diff[FTW_W-1:0] > f_stop))
                next_ftw = dn_diff[FTW_W-1:0];
        end
        at_end    = (o_cur_ftw == f_stop) || (f_step == '0);
        abort_now = abort_lat | i_abort;
    end

    // Sequencer: state, latched sweep parameters and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            f_start   <= '0;
            f_stop    <= '0;
            f_step    <= '0;
            dwell_lat <= DWELL_W'(1);
            dwell_cnt <= '0;
            mode_lat  <= '0;
            cont_lat  <= 1'b0;
            dir_up    <= 1'b1;
            abort_lat <= 1'b0;
            o_go      <= 1'b0;
            o_control <= CTRL_BASE;
            o_adreg0  <= ADREG_RST;
            o_adreg1  <= ADREG_RST;
            o_cur_ftw <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if ((state != S_IDLE) && i_abort)
                abort_lat <= 1'b1;

            case (state)
                S_IDLE: begin
                    abort_lat <= 1'b0;
                    if (i_start) begin
                        f_start   <= i_f_start;
                        f_stop    <= i_f_stop;
                        f_step    <= i_f_step;
                        dwell_lat <= (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
                        mode_lat  <= i_mode;
                        cont_lat  <= i_continuous;
                        dir_up    <= (i_f_stop >= i_f_start);
                        abort_lat <= i_abort;
                        o_cur_ftw <= i_f_start;
                        o_busy    <= 1'b1;
                        state     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (abort_now) begin
                        o_done <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        o_control <= CTRL_BASE | mode_bits(mode_lat);
                        o_adreg0  <= {FREQ0_TAG, o_cur_ftw[HALF_W-1:0]};
                        o_adreg1  <= {FREQ0_TAG, o_cur_ftw[FTW_W-1:HALF_W]};
                        o_go      <= 1'b1;
                        state     <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (i_good_to_reset_go) begin
                        o_go  <= 1'b0;
                        state <= S_SEND_WAIT;
                    end
                end

                // An abort is only honoured once the transfer has finished.
                S_SEND_WAIT: begin
                    if (i_send_complete) begin
                        if (abort_now) begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            dwell_cnt <= dwell_lat;
                            state     <= S_DWELL;
                        end
                    end
                end

                S_DWELL: begin
                    if (abort_now) begin
                        o_done <= 1'b1;
                        state  <= S_DONE;
                    end else if (dwell_cnt <= DWELL_W'(1)) begin
                        state <= S_NEXT;
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end

                S_NEXT: begin
                    if (at_end) begin
                        if (cont_lat) begin
                            o_cur_ftw <= f_start;
                            state     <= S_LOAD;
                        end else begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end
                    end else begin
                        o_cur_ftw <= next_ftw;
                        state     <= S_LOAD;
                    end
                end

                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9833_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ad9833_sweep_ctrl
// Self-checking bench for ad9833_sweep_ctrl. A responder plays the ad9833if
// side of the handshake with programmable delays; a monitor logs every
// transfer, done pulse and handshake/stability violations; each test task
// compares the log against a sweep model computed with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_ad9833_sweep_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic        i_abort;
    logic        i_continuous;
    logic [1:0]  i_mode;
    logic [27:0] i_f_start;
    logic [27:0] i_f_stop;
    logic [27:0] i_f_step;
    logic [31:0] i_dwell;
    logic        i_good_to_reset_go;
    logic        i_send_complete;
    logic        o_go;
    logic [15:0] o_control;
    logic [15:0] o_adreg0;
    logic [15:0] o_adreg1;
    logic [27:0] o_cur_ftw;
    logic        o_busy;
    logic        o_done;

    ad9833_sweep_ctrl #(.DWELL_W(32), .CTRL_BASE(16'h2000)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_start            (i_start),
        .i_abort            (i_abort),
        .i_continuous       (i_continuous),
        .i_mode             (i_mode),
        .i_f_start          (i_f_start),
        .i_f_stop           (i_f_stop),
        .i_f_step           (i_f_step),
        .i_dwell            (i_dwell),
        .i_good_to_reset_go (i_good_to_reset_go),
        .i_send_complete    (i_send_complete),
        .o_go               (o_go),
        .o_control          (o_control),
        .o_adreg0           (o_adreg0),
        .o_adreg1           (o_adreg1),
        .o_cur_ftw          (o_cur_ftw),
        .o_busy             (o_busy),
        .o_done             (o_done)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    int ack_dly = 1;
    int send_dly = 3;

    logic [15:0] ctl_tab [4] = '{16'h2000, 16'h2002, 16'h2020, 16'h2028};

    logic [27:0] mon_ftw [$];
    logic [15:0] mon_a0 [$];
    logic [15:0] mon_a1 [$];
    logic [15:0] mon_ctl [$];
    int          gap_q [$];
    int          dgap_q [$];
    int          done_cnt = 0;
    int          go_err = 0;
    int          stab_err = 0;
    logic [27:0] exp_q [$];

    // ad9833if stand-in: ack after ack_dly cycles, complete after send_dly more.
    initial begin : responder
        int rs;
        int cnt;
        rs = 0;
        cnt = 0;
        i_good_to_reset_go = 1'b0;
        i_send_complete = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            i_good_to_reset_go = 1'b0;
            i_send_complete = 1'b0;
            case (rs)
                0: if (o_go === 1'b1) begin cnt = ack_dly; rs = 1; end
                1: begin
                    if (o_go !== 1'b1) rs = 0;
                    else if (cnt == 0) begin i_good_to_reset_go = 1'b1; cnt = send_dly; rs = 2; end
                    else cnt--;
                end
                default: begin
                    if (cnt == 0) begin i_send_complete = 1'b1; rs = 0; end
                    else cnt--;
                end
            endcase
        end
    end

    // Transfer log plus go-hold and word-stability watch.
    initial begin : monitor
        logic pgo, pack, prst, in_xfer, have_sc;
        logic [15:0] s0, s1, sc;
        int cyc, last_sc;
        pgo = 0; pack = 0; prst = 0; in_xfer = 0; have_sc = 0;
        s0 = '0; s1 = '0; sc = '0; cyc = 0; last_sc = 0;
        forever begin
            @(posedge i_clk); #2;
            cyc++;
            if (!prst) begin
                in_xfer = 0;
                have_sc = 0;
            end else if (pgo && (o_go !== !pack)) begin
                go_err++;
            end
            if (o_go === 1'b1 && !pgo) begin
                mon_ftw.push_back(o_cur_ftw);
                mon_a0.push_back(o_adreg0);
                mon_a1.push_back(o_adreg1);
                mon_ctl.push_back(o_control);
                s0 = o_adreg0; s1 = o_adreg1; sc = o_control;
                in_xfer = 1;
                if (have_sc) gap_q.push_back(cyc - last_sc);
                have_sc = 0;
            end else if (in_xfer && ({o_adreg0, o_adreg1, o_control} !== {s0, s1, sc})) begin
                stab_err++;
            end
            if (in_xfer && i_send_complete) begin
                in_xfer = 0;
                have_sc = 1;
                last_sc = cyc;
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                dgap_q.push_back(have_sc ? cyc - last_sc : -1);
                have_sc = 0;
            end
            pgo = (o_go === 1'b1);
            pack = i_good_to_reset_go;
            prst = i_rst_n;
        end
    end

    // Reference sweep: list of programmed tuning words.
    task automatic build_expected(input logic [27:0] fs, input logic [27:0] fe, input logic [27:0] st);
        longint cur, nxt, s, e, b;
        s = longint'(st); e = longint'(fe); b = longint'(fs);
        exp_q.delete();
        cur = b;
        exp_q.push_back(fs);
        while (cur != e && s != 0 && exp_q.size() < 1000) begin
            if (e >= b) nxt = (cur + s > e) ? e : cur + s;
            else        nxt = (cur - s < e) ? e : cur - s;
            exp_q.push_back(28'(nxt));
            cur = nxt;
        end
    endtask

    task automatic start_sweep(input logic [27:0] fs, input logic [27:0] fe, input logic [27:0] st,
                               input logic [31:0] dw, input logic [1:0] md, input logic cont,
                               input logic ab);
        @(posedge i_clk); #1;
        i_f_start = fs; i_f_stop = fe; i_f_step = st; i_dwell = dw;
        i_mode = md; i_continuous = cont; i_start = 1'b1; i_abort = ab;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_abort = 1'b0;
        // Scramble parameters: the DUT must be working from its latched copy.
        i_f_start = 28'($urandom); i_f_stop = 28'($urandom); i_f_step = 28'($urandom);
        i_dwell = $urandom; i_mode = 2'($urandom); i_continuous = 1'($urandom);
    endtask

    task automatic wait_done(input int base, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge i_clk); #3;
            if (done_cnt > base) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0; i_start = 0; i_abort = 0; i_continuous = 0; i_mode = 0;
        i_f_start = 0; i_f_stop = 0; i_f_step = 0; i_dwell = 0;
        repeat (3) @(posedge i_clk); #1;
        tests++; if (o_go !== 1'b0) begin fails++; $display("FAIL reset_go: got %b expected 0", o_go); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        tests++; if (o_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", o_done); end
        tests++; if (o_cur_ftw !== 28'h0) begin fails++; $display("FAIL reset_ftw: got %h expected 0", o_cur_ftw); end
        tests++; if (o_control !== 16'h2000) begin fails++; $display("FAIL reset_control: got %h expected 2000", o_control); end
        tests++; if ({o_adreg0, o_adreg1} !== 32'h40004000) begin fails++; $display("FAIL reset_adreg: got %h %h expected 4000 4000", o_adreg0, o_adreg1); end
        i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk); #1;
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_up_sweep;
        int bt, bd; bit ok; logic [75:0] g, e;
        ack_dly = 1; send_dly = 3;
        bt = mon_ftw.size(); bd = done_cnt;
        build_expected(28'd1000, 28'd1300, 28'd100);
        start_sweep(28'd1000, 28'd1300, 28'd100, 32'd10, 2'd0, 1'b0, 1'b0);
        tests++; if ({o_go, o_busy} !== 2'b01) begin fails++; $display("FAIL up_latency1: go/busy got %b%b expected 01", o_go, o_busy); end
        @(posedge i_clk); #1;
        tests++; if (o_go !== 1'b1) begin fails++; $display("FAIL up_latency2: go got %b expected 1", o_go); end
        wait_done(bd, 500, ok);
        tests++; if (!ok) begin fails++; $display("FAIL up_timeout: done got 0 expected 1"); end
        tests++; if (mon_ftw.size() - bt !== 4) begin fails++; $display("FAIL up_count: got %0d expected 4", mon_ftw.size() - bt); end
        else begin
            for (int i = 0; i < 4; i++) begin
                g = {mon_ftw[bt+i], mon_a0[bt+i], mon_a1[bt+i], mon_ctl[bt+i]};
                e = {exp_q[i], 16'(16'h4000 + exp_q[i] % 28'd16384), 16'(16'h4000 + exp_q[i] / 28'd16384), ctl_tab[0]};
                tests++; if (g !== e) begin fails++; $display("FAIL up_point%0d: got %h expected %h", i, g, e); end
            end
            tests++; if ({mon_a0[bt], mon_a1[bt], mon_ctl[bt]} !== 48'h43E8_4000_2000) begin fails++;
                $display("FAIL up_first_words: got %h %h %h expected 43e8 4000 2000", mon_a0[bt], mon_a1[bt], mon_ctl[bt]); end
        end
        repeat (3) @(posedge i_clk); #3;
        tests++; if (done_cnt - bd !== 1) begin fails++; $display("FAIL up_done_count: got %0d expected 1", done_cnt - bd); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL up_busy_after: got %b expected 0", o_busy); end
    endtask

    task automatic test_clamp_down;
        int bt, bd; bit ok; logic [27:0] want [3]; logic [75:0] g, e;
        want = '{28'hABCDEF, 28'hABCD6F, 28'hABCD00};
        ack_dly = 2; send_dly = 2;
        bt = mon_ftw.size(); bd = done_cnt;
        start_sweep(28'h0ABCDEF, 28'h0ABCD00, 28'h80, 32'd3, 2'd3, 1'b0, 1'b0);
        wait_done(bd, 500, ok);
        tests++; if (!ok) begin fails++; $display("FAIL down_timeout: done got 0 expected 1"); end
        tests++; if (mon_ftw.size() - bt !== 3) begin fails++; $display("FAIL down_count: got %0d expected 3", mon_ftw.size() - bt); end
        else begin
            for (int i = 0; i < 3; i++) begin
                g = {mon_ftw[bt+i], mon_a0[bt+i], mon_a1[bt+i], mon_ctl[bt+i]};
                e = {want[i], 16'(16'h4000 + want[i] % 28'd16384), 16'(16'h4000 + want[i] / 28'd16384), 16'h2028};
                tests++; if (g !== e) begin fails++; $display("FAIL down_point%0d: got %h expected %h", i, g, e); end
            end
            tests++; if (mon_a1[bt] !== 16'h42AF) begin fails++; $display("FAIL down_adreg1: got %h expected 42af", mon_a1[bt]); end
        end
    endtask

    task automatic test_handshake;
        int bt, bd, bg, bdg, ge, se; bit ok;
        ack_dly = 7; send_dly = 40;
        bt = mon_ftw.size(); bd = done_cnt; bg = gap_q.size(); bdg = dgap_q.size();
        ge = go_err; se = stab_err;
        start_sweep(28'd10, 28'd30, 28'd10, 32'd5, 2'd1, 1'b0, 1'b0);
        wait_done(bd, 1000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL hs_timeout: done got 0 expected 1"); end
        tests++; if (mon_ftw.size() - bt !== 3) begin fails++; $display("FAIL hs_count: got %0d expected 3", mon_ftw.size() - bt); end
        tests++; if (go_err - ge !== 0) begin fails++; $display("FAIL hs_go_hold: got %0d violations expected 0", go_err - ge); end
        tests++; if (stab_err - se !== 0) begin fails++; $display("FAIL hs_word_stable: got %0d violations expected 0", stab_err - se); end
        tests++; if (gap_q.size() - bg !== 2) begin fails++; $display("FAIL hs_gap_count: got %0d expected 2", gap_q.size() - bg); end
        else for (int i = 0; i < 2; i++) begin
            tests++; if (gap_q[bg+i] !== 8) begin fails++; $display("FAIL hs_dwell_gap%0d: got %0d expected 8", i, gap_q[bg+i]); end
        end
        tests++; if (dgap_q.size() - bdg !== 1 || dgap_q[bdg] !== 7) begin fails++;
            $display("FAIL hs_done_gap: got %0d entries expected 1 with value 7", dgap_q.size() - bdg); end
        ack_dly = 1; send_dly = 3;
    endtask

    task automatic test_abort_mid;
        int bt, bd; bit ok;
        ack_dly = 2; send_dly = 10;
        bt = mon_ftw.size(); bd = done_cnt;
        start_sweep(28'd1000, 28'd2000, 28'd100, 32'd4, 2'd2, 1'b0, 1'b0);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge i_clk); #3;
            if (mon_ftw.size() >= bt + 2) begin ok = 1; break; end
        end
        tests++; if (!ok) begin fails++; $display("FAIL abort_wait_point2: reached 0 expected 1"); end
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge i_clk); #1;
            if (o_go === 1'b0) begin ok = 1; break; end
        end
        tests++; if (!ok) begin fails++; $display("FAIL abort_wait_ack: go dropped 0 expected 1"); end
        i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        wait_done(bd, 200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL abort_timeout: done got 0 expected 1"); end
        repeat (20) @(posedge i_clk); #3;
        tests++; if (mon_ftw.size() - bt !== 2) begin fails++; $display("FAIL abort_transfers: got %0d expected 2", mon_ftw.size() - bt); end
        else begin
            tests++; if ({mon_ftw[bt], mon_ftw[bt+1]} !== {28'd1000, 28'd1100}) begin fails++;
                $display("FAIL abort_ftw: got %0d %0d expected 1000 1100", mon_ftw[bt], mon_ftw[bt+1]); end
        end
        tests++; if (done_cnt - bd !== 1) begin fails++; $display("FAIL abort_done_count: got %0d expected 1", done_cnt - bd); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", o_busy); end
        ack_dly = 1; send_dly = 3;
    endtask

    task automatic test_continuous;
        int bt, bd; bit ok; logic [27:0] want [5];
        want = '{28'd5, 28'd6, 28'd7, 28'd5, 28'd6};
        ack_dly = 1; send_dly = 2;
        bt = mon_ftw.size(); bd = done_cnt;
        start_sweep(28'd5, 28'd7, 28'd1, 32'd20, 2'd0, 1'b1, 1'b0);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge i_clk); #3;
            if (mon_ftw.size() >= bt + 5) begin ok = 1; break; end
        end
        tests++; if (!ok) begin fails++; $display("FAIL cont_five_points: reached 0 expected 1"); end
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge i_clk); #2;
            if (i_send_complete) begin ok = 1; break; end
        end
        tests++; if (!ok) begin fails++; $display("FAIL cont_wait_complete: seen 0 expected 1"); end
        @(posedge i_clk); #1;
        i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        wait_done(bd, 1, ok);
        tests++; if (!ok) begin fails++; $display("FAIL cont_abort_latency: done within 2 cycles got 0 expected 1"); end
        repeat (25) @(posedge i_clk); #3;
        tests++; if (mon_ftw.size() - bt !== 5) begin fails++; $display("FAIL cont_transfers: got %0d expected 5", mon_ftw.size() - bt); end
        else for (int i = 0; i < 5; i++) begin
            tests++; if (mon_ftw[bt+i] !== want[i]) begin fails++; $display("FAIL cont_ftw%0d: got %0d expected %0d", i, mon_ftw[bt+i], want[i]); end
        end
        tests++; if (done_cnt - bd !== 1) begin fails++; $display("FAIL cont_done_count: got %0d expected 1", done_cnt - bd); end
    endtask

    task automatic test_edge;
        int bt, bd, bdg; bit ok;
        ack_dly = 1; send_dly = 1;
        // zero step and zero dwell
        bt = mon_ftw.size(); bd = done_cnt; bdg = dgap_q.size();
        start_sweep(28'd123, 28'd456, 28'd0, 32'd0, 2'd1, 1'b0, 1'b0);
        wait_done(bd, 200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL edge_step0_timeout: done got 0 expected 1"); end
        tests++; if (mon_ftw.size() - bt !== 1) begin fails++; $display("FAIL edge_step0_count: got %0d expected 1", mon_ftw.size() - bt); end
        tests++; if (dgap_q.size() - bdg !== 1 || dgap_q[bdg] !== 3) begin fails++;
            $display("FAIL edge_dwell0_gap: got %0d entries expected 1 with value 3", dgap_q.size() - bdg); end
        // 28-bit wrap clamps onto stop
        bt = mon_ftw.size(); bd = done_cnt;
        start_sweep(28'hFFFFFF0, 28'hFFFFFFF, 28'h20, 32'd2, 2'd0, 1'b0, 1'b0);
        wait_done(bd, 200, ok);
        tests++; if (mon_ftw.size() - bt !== 2) begin fails++; $display("FAIL edge_wrap_count: got %0d expected 2", mon_ftw.size() - bt); end
        else begin
            tests++; if (mon_ftw[bt+1] !== 28'hFFFFFFF) begin fails++; $display("FAIL edge_wrap_clamp: got %h expected fffffff", mon_ftw[bt+1]); end
        end
        // start and abort together: no transfer, one done
        bt = mon_ftw.size(); bd = done_cnt;
        start_sweep(28'd50, 28'd90, 28'd10, 32'd2, 2'd0, 1'b0, 1'b1);
        repeat (10) @(posedge i_clk); #3;
        tests++; if ({mon_ftw.size() - bt, done_cnt - bd} !== {32'd0, 32'd1}) begin fails++;
            $display("FAIL edge_start_abort: transfers/dones got %0d/%0d expected 0/1", mon_ftw.size() - bt, done_cnt - bd); end
        // reset while waiting for the ack
        ack_dly = 30;
        bd = done_cnt;
        start_sweep(28'h1234567, 28'h2000000, 28'h1000, 32'd2, 2'd2, 1'b0, 1'b0);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk); #1;
            if (o_go === 1'b1) begin ok = 1; break; end
        end
        tests++; if (!ok) begin fails++; $display("FAIL edge_rst_wait_go: go got 0 expected 1"); end
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        tests++; if (o_go !== 1'b0) begin fails++; $display("FAIL edge_rst_go: got %b expected 0", o_go); end
        tests++; if ({o_busy, o_done, o_cur_ftw, o_control, o_adreg0, o_adreg1} !== {2'b00, 28'h0, 16'h2000, 16'h4000, 16'h4000}) begin fails++;
            $display("FAIL edge_rst_outputs: got %b %b %h %h %h %h expected 0 0 0 2000 4000 4000", o_busy, o_done, o_cur_ftw, o_control, o_adreg0, o_adreg1); end
        i_rst_n = 1'b1;
        repeat (5) @(posedge i_clk); #3;
        tests++; if ({o_go, o_busy} !== 2'b00 || done_cnt != bd) begin fails++;
            $display("FAIL edge_rst_after: go/busy got %b%b dones %0d expected 00 and 0", o_go, o_busy, done_cnt - bd); end
        ack_dly = 1; send_dly = 3;
    endtask

    task automatic test_random;
        int bt, bd, n; bit ok; logic [75:0] g, e;
        logic [27:0] fs, fe, st; logic [1:0] md; longint span, t;
        for (int it = 0; it < 8; it++) begin
            fs = 28'($urandom);
            st = ($urandom_range(0, 7) == 0) ? 28'd0 : 28'($urandom_range(1, 4000));
            span = longint'($urandom_range(0, 8 * 4000));
            if (st != 0) span = span % (longint'(st) * 8 + 1);
            t = $urandom_range(0, 1) ? longint'(fs) + span : longint'(fs) - span;
            if (t > 64'h0FFFFFFF) t = 64'h0FFFFFFF;
            if (t < 0) t = 0;
            fe = 28'(t);
            md = 2'($urandom);
            ack_dly = $urandom_range(0, 4); send_dly = $urandom_range(0, 6);
            bt = mon_ftw.size(); bd = done_cnt;
            build_expected(fs, fe, st);
            start_sweep(fs, fe, st, 32'($urandom_range(0, 6)), md, 1'b0, 1'b0);
            wait_done(bd, 3000, ok);
            tests++; if (!ok) begin fails++; $display("FAIL rand%0d_timeout: done got 0 expected 1", it); end
            n = exp_q.size();
            tests++; if (mon_ftw.size() - bt !== n) begin fails++;
                $display("FAIL rand%0d_count: got %0d expected %0d (start %h stop %h step %h)", it, mon_ftw.size() - bt, n, fs, fe, st); end
            else for (int i = 0; i < n; i++) begin
                g = {mon_ftw[bt+i], mon_a0[bt+i], mon_a1[bt+i], mon_ctl[bt+i]};
                e = {exp_q[i], 16'(16'h4000 + exp_q[i] % 28'd16384), 16'(16'h4000 + exp_q[i] / 28'd16384), ctl_tab[md]};
                tests++; if (g !== e) begin fails++; $display("FAIL rand%0d_point%0d: got %h expected %h", it, i, g, e); end
            end
            repeat (3) @(posedge i_clk); #3;
            tests++; if (o_busy !== 1'b0 || done_cnt - bd !== 1) begin fails++;
                $display("FAIL rand%0d_end: busy %b dones %0d expected 0 and 1", it, o_busy, done_cnt - bd); end
        end
        tests++; if (go_err !== 0 || stab_err !== 0) begin fails++;
            $display("FAIL global_handshake: go violations %0d word violations %0d expected 0 and 0", go_err, stab_err); end
    endtask

    initial begin
        test_reset;
        test_up_sweep;
        test_clamp_down;
        test_handshake;
        test_abort_mid;
        test_continuous;
        test_edge;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ad9833_sweep_ctrl.md
Name: ad9833_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the AD9833 SPI interface block (ad9833if) through its go / good_to_reset_go / send_complete handshake. It takes a start/stop/step tuning-word triple and a dwell time, then issues one three-word transfer (control, FREQ0 LSB, FREQ0 MSB) per sweep point. It replaces the free-running once-per-second go generator in the top level and supports single-shot or continuous sweeps with a safe abort.

Parameters:
DWELL_W, 32, width of dwell counter and i_dwell
CTRL_BASE, 16'h2000, control word base (B28=1, FREQ0/PHASE0 selected)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
i_start  in  1  start sweep; sampled only in IDLE
i_abort  in  1  request stop at next safe point
i_continuous  in  1  repeat sweep until aborted; latched on start
i_mode  in  2  waveform: 0 sine, 1 triangle, 2 square/2, 3 square
i_f_start  in  28  first tuning word
i_f_stop  in  28  last tuning word
i_f_step  in  28  step magnitude
i_dwell  in  DWELL_W  cycles to hold each point after transfer completes
i_good_to_reset_go  in  1  ad9833if has accepted go
i_send_complete  in  1  ad9833if finished the three-word transfer
o_go  out  1  transfer request to ad9833if
o_control  out  16  control word
o_adreg0  out  16  FREQ0 LSB word
o_adreg1  out  16  FREQ0 MSB word
o_cur_ftw  out  28  tuning word currently programmed or in flight
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse on sweep end (normal or abort)

Behaviour:
- Reset (i_rst_n=0 at posedge): state IDLE; o_go=0, o_busy=0, o_done=0, o_cur_ftw=0, o_control=CTRL_BASE, o_adreg0=16'h4000, o_adreg1=16'h4000, abort latch cleared. Reset mid-transfer drops o_go immediately; this block does not reset ad9833if.
- Word formats: o_control = CTRL_BASE | mode bits (0:0x0000, 1:0x0002, 2:0x0020, 3:0x0028); o_adreg0 = {2'b01, ftw[13:0]}; o_adreg1 = {2'b01, ftw[27:14]}. All three words are registered and stable from o_go rising until i_send_complete is seen.
- On start: i_f_start, i_f_stop, i_f_step, i_dwell, i_mode and i_continuous are latched. Direction is up if f_stop >= f_start, otherwise down. A latched dwell of 0 is treated as 1.
- States:
  - IDLE: on i_start go to LOAD.
  - LOAD: update words from cur_ftw (one cycle); go to REQ.
  - REQ: o_go=1 and held; on i_good_to_reset_go=1, o_go=0 the next cycle; go to SEND_WAIT.
  - SEND_WAIT: wait for i_send_complete=1; go to DWELL, counter = dwell.
  - DWELL: decrement each cycle; at 1, go to NEXT.
  - NEXT: compute next point (see stepping); go to LOAD, or DONE.
  - DONE: o_done=1 for one cycle; go to IDLE.
- Sweep latency: start to o_go is 2 cycles (IDLE->LOAD->REQ).
- Stepping: next = cur ± step. If cur == stop, or step == 0, the sweep ends. If the computed next passes stop or wraps past the 28-bit range, next = stop (clamped final point).
- End of sweep: if continuous, cur = f_start and go to LOAD; otherwise go to DONE.
- Abort handling:
  - i_abort sets a latch in any busy state.
  - In LOAD, the latch goes to DONE without a transfer.
  - In REQ or SEND_WAIT, the transfer is never cut short; the abort is honoured on completion.
  - In DWELL, the latch ends the dwell immediately and goes to DONE.
  - The latch is cleared in IDLE.
- i_start is ignored while busy. Simultaneous i_start and i_abort in IDLE: start wins, and the abort is latched and takes effect at the first safe point.

Test Plan:
- Up sweep: start=1000, stop=1300, step=100, dwell=10, mode=0 -> four transfers with ftw 1000,1100,1200,1300; first o_adreg0=0x43E8, o_adreg1=0x4000, o_control=0x2000; single o_done; o_busy low after.
- Clamp/down: start=0x0ABCDEF, stop=0x0ABCD00, step=0x80, mode=3 -> ftw 0xABCDEF, 0xABCD6F, 0xABCD00; o_control=0x2028; o_adreg1=0x42AF.
- Handshake: delay i_good_to_reset_go 7 cycles, i_send_complete 40 cycles -> o_go held exactly until ack+1, words stable throughout, dwell counted from send_complete.
- Abort mid-transfer: assert i_abort while in SEND_WAIT of point 2 -> that transfer completes, no further o_go, o_done pulses once.
- Continuous: start=5, stop=7, step=1, continuous=1 -> ftw sequence 5,6,7,5,6,...; abort in DWELL -> o_done within 2 cycles.
- Edge: step=0, and dwell=0 -> single transfer, dwell of 1 cycle, then done; synchronous reset asserted in REQ -> o_go=0 and all outputs at reset values next cycle.
